// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
//  muldiv_iter : iterative MULT/MULTU/DIV/DIVU unit, fixed WIDTH+2 latency.
//  Signed ops need `MULDIV_SIGNED_EN; otherwise all arithmetic is unsigned.
//  Revision    : 1.0
// ============================================================================
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int             CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      RUN  = 2'd2,
      FIX  = 2'd3
   } state_t;

   state_t               state;
   state_t               state_nx;

   logic [WIDTH-1:0]     a_r;
   logic [WIDTH-1:0]     b_r;
   logic [WIDTH-1:0]     x_r;
   logic [WIDTH-1:0]     y_r;
   logic                 is_div;
   logic [2*WIDTH-1:0]   acc;
   logic [CW-1:0]        cnt;

   logic                 w_dz;
   logic [WIDTH-1:0]     w_ma;
   logic [WIDTH-1:0]     w_mb;
   logic [WIDTH-1:0]     w_x;
   logic [WIDTH-1:0]     w_y;
   logic [2*WIDTH-1:0]   w_acc;
   logic [WIDTH:0]       w_sum;
   logic [WIDTH:0]       w_sub;
   logic                 w_ge;
   logic [2*WIDTH-1:0]   w_step;
   logic [WIDTH-1:0]     w_hi;
   logic [WIDTH-1:0]     w_lo;
   logic                 unused_sub;

   assign w_dz       = start & op[1] & (b == '0);
   assign unused_sub = w_sub[WIDTH];

`ifdef MULDIV_SIGNED_EN
   logic sgn_r;
   logic neg_q;
   logic neg_r;

   assign w_ma = (sgn_r & a_r[WIDTH-1]) ? -a_r : a_r;
   assign w_mb = (sgn_r & b_r[WIDTH-1]) ? -b_r : b_r;

   always_comb begin
      {w_hi, w_lo} = neg_q ? -acc : acc;
      if (is_div) begin
         w_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
         w_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sgn_r <= 1'b0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (state == IDLE && start) begin
         sgn_r <= ~op[0];
      end else if (state == PREP) begin
         neg_q <= sgn_r & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
         neg_r <= sgn_r & a_r[WIDTH-1];
      end
   end
`else
   logic unused_op0;

   assign unused_op0   = op[0];
   assign w_ma         = a_r;
   assign w_mb         = b_r;
   assign {w_hi, w_lo} = acc;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = (state != IDLE);
      case (state)
         IDLE:    if (start && !w_dz) state_nx = PREP;
         PREP:    state_nx = RUN;
         RUN:     if (cnt == LAST) state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // PREP performs the first iteration on the fresh magnitudes, so the
   // remaining WIDTH-1 steps fit in RUN and FIX commits at E(WIDTH+1).
   always_comb begin
      w_x   = x_r;
      w_y   = y_r;
      w_acc = acc;
      if (state == PREP) begin
         w_x   = is_div ? w_mb : w_ma;
         w_y   = w_mb;
         w_acc = is_div ? {{WIDTH{1'b0}}, w_ma} : '0;
      end
      w_sum = {1'b0, w_acc[2*WIDTH-1:WIDTH]} + (w_y[0] ? {1'b0, w_x} : '0);
      w_sub = w_acc[2*WIDTH-1:WIDTH-1] - {1'b0, w_x};
      w_ge  = (w_acc[2*WIDTH-1:WIDTH-1] >= {1'b0, w_x});
      if (is_div)
         w_step = {(w_ge ? w_sub[WIDTH-1:0] : w_acc[2*WIDTH-2:WIDTH-1]),
                   w_acc[WIDTH-2:0], w_ge};
      else
         w_step = {w_sum, w_acc[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         a_r      <= '0;
         b_r      <= '0;
         x_r      <= '0;
         y_r      <= '0;
         is_div   <= 1'b0;
         acc      <= '0;
         cnt      <= '0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_r    <= a;
                  b_r    <= b;
                  is_div <= op[1];
                  if (w_dz) begin
                     done     <= 1'b1;
                     div_zero <= 1'b1;
                  end
               end
            end
            PREP: begin
               x_r <= w_x;
               y_r <= w_y >> 1;
               acc <= w_step;
               cnt <= CW'(1);
            end
            RUN: begin
               y_r <= w_y >> 1;
               acc <= w_step;
               cnt <= cnt + CW'(1);
            end
            FIX: begin
               hi   <= w_hi;
               lo   <= w_lo;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  tb_muldiv_iter : scoreboard bench for muldiv_iter with a behavioural model.
//  Revision       : 1.0
// ============================================================================
module tb_muldiv_iter;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic          div_zero;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } exp_t;

   exp_t          sb[$];
   int            checks   = 0;
   int            failures = 0;
   logic [W-1:0]  m_hi     = '0;
   logic [W-1:0]  m_lo     = '0;

   always #5 clk = ~clk;

   muldiv_iter #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x,
                                  input logic [W-1:0] y);
      exp_t         e;
      logic [2*W-1:0] p;
      logic [W-1:0] qq;
      logic [W-1:0] rr;
      bit           sgn;
`ifdef MULDIV_SIGNED_EN
      sgn = !o[0];
`else
      sgn = 1'b0;
`endif
      e.dz = 1'b0;
      if (!o[1]) begin
         if (sgn) p = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
         else     p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
         e.hi = p[2*W-1:W];
         e.lo = p[W-1:0];
      end else if (y == '0) begin
         e.dz = 1'b1;
         e.hi = m_hi;
         e.lo = m_lo;
      end else begin
         if (sgn) begin
            if (x == {1'b1, {(W-1){1'b0}}} && y == '1) begin
               qq = x;
               rr = '0;
            end else begin
               qq = $signed(x) / $signed(y);
               rr = $signed(x) % $signed(y);
            end
         end else begin
            qq = x / y;
            rr = x % y;
         end
         e.hi = rr;
         e.lo = qq;
      end
      return e;
   endfunction

   // Scoreboard monitor: every done pulse consumes one expectation.
   always @(negedge clk) begin : mon
      exp_t e;
      if (!reset && done) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_done: got done with empty scoreboard hi=%h lo=%h", hi, lo);
         end else begin
            e = sb.pop_front();
            if ({hi, lo, div_zero, busy} !== {e.hi, e.lo, e.dz, 1'b0}) begin
               failures++;
               $display("FAIL result: got hi=%h lo=%h dz=%b busy=%b, expected hi=%h lo=%h dz=%b busy=0",
                        hi, lo, div_zero, busy, e.hi, e.lo, e.dz);
            end
         end
      end
   end

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return {1'b1, {(W-1){1'b0}}};
         2:       return '1;
         3:       return W'($urandom_range(1, 20));
         default: return W'($urandom);
      endcase
   endfunction

   // Entered and left on a falling edge; leaving in the done cycle lets the
   // next call assert start back-to-back.
   task automatic issue(input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit interfere);
      exp_t e;
      int   n;
      bit   busy_ok;
      e = model(o, x, y);
      sb.push_back(e);
      if (!e.dz) begin
         m_hi = e.hi;
         m_lo = e.lo;
      end
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start   = 1'b0;
      op      = 2'($urandom);
      a       = W'($urandom);
      b       = W'($urandom);
      n       = 1;
      busy_ok = 1'b1;
      while (!done && n < W + 10) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (interfere && n == 5) begin
            start = 1'b1;
            op    = 2'($urandom);
            a     = pick();
            b     = pick();
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         n++;
      end
      start = 1'b0;
      checks++;
      if (!done || n != (e.dz ? 1 : W + 2)) begin
         failures++;
         $display("FAIL latency: got %0d cycles (done=%b), expected %0d", n, done, e.dz ? 1 : W + 2);
      end
      checks++;
      if (!busy_ok) begin
         failures++;
         $display("FAIL busy_during_op: busy dropped before done, expected 1 throughout");
      end
      @(negedge clk);
   endtask

   task automatic check_hl(input string name, input logic [W-1:0] eh, input logic [W-1:0] el);
      checks++;
      if (hi !== eh || lo !== el) begin
         failures++;
         $display("FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h", name, hi, lo, eh, el);
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int dones;
      reset = 1'b1;
      start = 1'b0;
      op    = '0;
      a     = '0;
      b     = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, div_zero, hi, lo} !== '0) begin
         failures++;
         $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%h lo=%h, expected all 0",
                  busy, done, div_zero, hi, lo);
      end
      reset = 1'b0;
      @(negedge clk);

      issue(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0);
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check_hl("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
      issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
      issue(2'b11, 32'd100, 32'd7, 1'b0);
      check_hl("divu_100_7", 32'd2, 32'd14);
      issue(2'b11, 32'd5, 32'd0, 1'b0);
      check_hl("divu_by_zero_hold", 32'd2, 32'd14);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL dz_aftermath: got busy=%b done=%b, expected 0 0", busy, done);
      end

      // Abort a multiply: ignored re-start at cycle 5, reset at cycle 10.
      start = 1'b1; op = 2'b01; a = 32'd7; b = 32'd9;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1 start = 1'b1; op = 2'b11; a = 32'd3; b = 32'd4;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      m_hi = '0;
      m_lo = '0;
      checks++;
      if ({busy, done, div_zero, hi, lo} !== '0) begin
         failures++;
         $display("FAIL mid_op_reset: got busy=%b done=%b dz=%b hi=%h lo=%h, expected all 0",
                  busy, done, div_zero, hi, lo);
      end
      dones = 0;
      repeat (W + 6) begin
         @(negedge clk);
         if (done) dones++;
      end
      checks++;
      if (dones != 0) begin
         failures++;
         $display("FAIL aborted_done: got %0d done pulses, expected 0", dones);
      end
      issue(2'b01, 32'd7, 32'd9, 1'b0);
      check_hl("multu_7x9", 32'd0, 32'd63);
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

      for (int i = 0; i < 60; i++) begin
         issue(2'($urandom), pick(), pick(), ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
